// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, start/done handshake.
// Round keys come from an external key expansion and are selected by the round counter.
`timescale 1ns/1ps
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [127:0]              cipher_text,
  input  logic [128*(NR+1)-1:0]     expanded_key,
  output logic [127:0]              plain_text,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} fsm_e;

  fsm_e          fsm_r;
  logic [3:0]    cnt_r;
  logic [127:0]  state_r;
  logic [3:0]    key_idx_s;
  logic [127:0]  rk_s;
  logic [127:0]  sub_s;
  logic [127:0]  ark_s;
  logic [127:0]  round_s;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Row r of column c takes the byte from column c-r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+4-r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [7:0]   a2;
    logic [7:0]   a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c    +: 8];
      a1 = s[32*c+8  +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c    +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[32*c+8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Round-key mux: IDLE needs the last key for the initial whitening, otherwise cnt selects
  always_comb begin
    key_idx_s = (fsm_r == IDLE) ? 4'(NR) : cnt_r;
    rk_s      = 128'h0;
    for (int r = 0; r <= NR; r++) begin
      rk_s = (key_idx_s == 4'(r)) ? expanded_key[128*r +: 128] : rk_s;
    end
  end

  assign sub_s   = inv_sub_bytes(inv_shift_rows(state_r));
  assign ark_s   = sub_s ^ rk_s;
  assign round_s = inv_mix_columns(ark_s);

  // Control FSM with registered state, counter and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_r      <= IDLE;
      cnt_r      <= 4'd0;
      state_r    <= 128'h0;
      plain_text <= 128'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= cipher_text ^ rk_s;
            cnt_r   <= 4'(NR - 1);
            busy    <= 1'b1;
            fsm_r   <= ROUND;
          end else begin
            busy    <= 1'b0;
          end
        end
        ROUND: begin
          state_r <= round_s;
          cnt_r   <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            fsm_r <= FINAL;
          end else begin
            fsm_r <= ROUND;
          end
        end
        FINAL: begin
          plain_text <= ark_s;
          done       <= 1'b1;
          busy       <= 1'b0;
          fsm_r      <= IDLE;
        end
        default: begin
          fsm_r <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
